// File: rtl/synth_pkg.sv
// Shared widths, default tick divider and FSM state encoding for the sample fetch path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package synth_pkg;

   localparam int ADDR_W       = 26;
   localparam int SAMPLE_W     = 16;
   localparam int TICK_DIV_DEF = 2083;   // 48 kHz output rate from a 100 MHz clock

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FETCH = 3'd1,
      ST_WAIT  = 3'd2,
      ST_DRAIN = 3'd3,
      ST_ABORT = 3'd4
   } state_t;

endpackage

// File: rtl/sample_fifo.sv
// Synchronous prefetch FIFO for audio words; head is visible combinationally.
// Latency: a pushed word is readable at the head one cycle after the push.
// Backpressure: push while full is dropped unless a pop happens in the same cycle; pop while empty is ignored.
module sample_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     push,
   input  logic [W-1:0]             push_data,
   input  logic                     pop,
   output logic [W-1:0]             head,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty,
   output logic                     full
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic          do_push;
   logic          do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign do_pop  = pop && !empty;
   // A full FIFO can still accept a word when the head leaves in the same cycle.
   assign do_push = push && (!full || do_pop);
   assign head    = mem[rd_ptr];

   // Storage array: written only, never reset.
   always_ff @(posedge clk) begin
      if (do_push && !flush)
         mem[wr_ptr] <= push_data;
   end

   // Pointers and occupancy; flush empties the FIFO and overrides any push/pop.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)
            rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/sample_fetch.sv
// Audio sample fetcher: prefetches words from RAM into a small FIFO and emits one per tick. Macro SAMPLE_FETCH_LOOP_EN selects endless looping.
// Latency: first sample appears TICK_DIV cycles after start; sample and sample_tick update on the same edge.
// Backpressure: one read outstanding; requests stop while the FIFO is full; an empty FIFO at a tick raises sticky underrun.
module sample_fetch
   import synth_pkg::*;
#(
   parameter int TICK_DIV   = TICK_DIV_DEF,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                stop,
   input  logic [ADDR_W-1:0]   base_addr,
   input  logic [ADDR_W-1:0]   length,
   output logic                mem_req,
   output logic [ADDR_W-1:0]   mem_addr,
   input  logic                mem_ready,
   input  logic                mem_valid,
   input  logic [SAMPLE_W-1:0] mem_data,
   output logic [SAMPLE_W-1:0] sample,
   output logic                sample_tick,
   output logic                busy,
   output logic                underrun
);

   localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   state_t              state;
   logic [ADDR_W-1:0]   base_q;
   logic [ADDR_W-1:0]   len_q;
   logic [ADDR_W-1:0]   offset;
   logic [ADDR_W-1:0]   offset_nxt;
   logic [TW-1:0]       tick_cnt;
   logic                wrap;
   logic                last;
   logic                stop_hit;
   logic                pop_ok;
   logic                fifo_push;
   logic                fifo_pop;
   logic [SAMPLE_W-1:0] fifo_head;
   logic [CW-1:0]       fifo_count;
   logic                fifo_empty;
   logic                fifo_full;

   assign busy       = (state != ST_IDLE);
   assign wrap       = busy && (tick_cnt == TW'(TICK_DIV - 1));
   assign offset_nxt = offset + ADDR_W'(1);
   assign last       = (offset_nxt == len_q);
   assign mem_req    = (state == ST_FETCH) && (fifo_count < CW'(FIFO_DEPTH));
   assign mem_addr   = base_q + offset;
   // stop only acts in states that own FIFO contents or an outstanding read
   assign stop_hit   = stop && ((state == ST_FETCH) || (state == ST_WAIT) || (state == ST_DRAIN));
   // ABORT never holds data: the FIFO was flushed on entry
   assign pop_ok     = !fifo_empty && (state != ST_ABORT);
   assign fifo_pop   = wrap && !stop_hit && pop_ok;
   // a response that coincides with stop belongs to the aborted playback
   assign fifo_push  = (state == ST_WAIT) && mem_valid && !stop && !fifo_full;

   sample_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (SAMPLE_W)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .flush     (stop_hit),
      .push      (fifo_push),
      .push_data (mem_data),
      .pop       (fifo_pop),
      .head      (fifo_head),
      .count     (fifo_count),
      .empty     (fifo_empty),
      .full      (fifo_full)
   );

   // Output-rate divider: free-runs 0..TICK_DIV-1 while busy, parked at 0 when idle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         tick_cnt <= '0;
      else if (!busy || wrap)
         tick_cnt <= '0;
      else
         tick_cnt <= tick_cnt + TW'(1);
   end

   // Playback FSM with registered sample, strobe and underrun outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= ST_IDLE;
         base_q      <= '0;
         len_q       <= '0;
         offset      <= '0;
         sample      <= '0;
         sample_tick <= 1'b0;
         underrun    <= 1'b0;
      end else begin
         sample_tick <= wrap;
         // Starvation only counts while the stream is still being fetched;
         // the empty tick that ends DRAIN is the normal end of playback.
         if (wrap && !stop_hit) begin
            if (pop_ok)
               sample <= fifo_head;
            else if ((state == ST_FETCH) || (state == ST_WAIT))
               underrun <= 1'b1;
         end
         case (state)
            ST_IDLE: begin
               if (start && !stop && (length != '0)) begin
                  base_q   <= base_addr;
                  len_q    <= length;
                  offset   <= '0;
                  underrun <= 1'b0;
                  state    <= ST_FETCH;
               end
            end
            ST_FETCH: begin
               if (stop) begin
                  sample <= '0;
                  state  <= ST_IDLE;
               end else if (mem_req && mem_ready) begin
                  state <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (stop) begin
                  sample <= '0;
                  // if the response lands with the stop there is nothing left to discard
                  state  <= mem_valid ? ST_IDLE : ST_ABORT;
               end else if (mem_valid) begin
                  if (last) begin
`ifdef SAMPLE_FETCH_LOOP_EN
                     offset <= '0;
                     state  <= ST_FETCH;
`else
                     offset <= offset_nxt;
                     state  <= ST_DRAIN;
`endif
                  end else begin
                     offset <= offset_nxt;
                     state  <= ST_FETCH;
                  end
               end
            end
            ST_DRAIN: begin
               if (stop) begin
                  sample <= '0;
                  state  <= ST_IDLE;
               end else if (wrap && fifo_empty) begin
                  state <= ST_IDLE;
               end
            end
            ST_ABORT: begin
               if (mem_valid)
                  state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sample_fetch.sv
// Bench for sample_fetch: RAM responder with configurable latency/readiness, reference stream model, directed and random playbacks.
// Latency: expected samples follow from word k of a playback being 0xA000 + (base + k), one per TICK_DIV cycles.
// Backpressure: readiness is randomised or held low to provoke underrun; SAMPLE_FETCH_LOOP_EN selects the looping checks.
module tb_sample_fetch;

   localparam int TD    = 20;
   localparam int DEPTH = 4;

   logic        clk;
   logic        rst;
   logic        start;
   logic        stop;
   logic [25:0] base_addr;
   logic [25:0] length;
   logic        mem_req;
   logic [25:0] mem_addr;
   logic        mem_ready;
   logic        mem_valid;
   logic [15:0] mem_data;
   logic [15:0] sample;
   logic        sample_tick;
   logic        busy;
   logic        underrun;

   int          n_assert = 0;
   int          n_fail   = 0;
   int          cyc      = 0;
   int          lat      = 2;
   int          ready_pct = 100;
   bit          ready_low = 0;
   bit          pend      = 0;
   int          pend_cnt  = 0;
   logic [25:0] pend_addr = '0;
   bit          saw_req   = 0;
   bit          saw_busy  = 0;
   bit          saw_idle  = 0;
   logic [25:0] acc_q [$];
   logic [15:0] obs_q [$];
   int          tcyc_q [$];

   sample_fetch #(
      .TICK_DIV   (TD),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .stop        (stop),
      .base_addr   (base_addr),
      .length      (length),
      .mem_req     (mem_req),
      .mem_addr    (mem_addr),
      .mem_ready   (mem_ready),
      .mem_valid   (mem_valid),
      .mem_data    (mem_data),
      .sample      (sample),
      .sample_tick (sample_tick),
      .busy        (busy),
      .underrun    (underrun)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #600000;
      $display("FAIL watchdog: time limit reached before end of test");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // RAM model and observer: everything happens at the falling edge, away from the DUT's edge.
   initial begin
      mem_ready = 1'b0;
      mem_valid = 1'b0;
      mem_data  = '0;
      forever begin
         @(negedge clk);
         cyc++;
         mem_valid = 1'b0;
         if (pend) begin
            if (pend_cnt == 0) begin
               mem_valid = 1'b1;
               mem_data  = 16'hA000 + pend_addr[15:0];
               pend      = 0;
            end else begin
               pend_cnt--;
            end
         end
         mem_ready = !ready_low && (int'($urandom_range(99)) < ready_pct);
         if (mem_req)  saw_req  = 1;
         if (busy)     saw_busy = 1;
         if (!busy)    saw_idle = 1;
         if (sample_tick) begin
            obs_q.push_back(sample);
            tcyc_q.push_back(cyc);
         end
         if (mem_req && mem_ready) begin
            check("one_outstanding", 32'(pend), 0);
            acc_q.push_back(mem_addr);
            pend      = 1;
            pend_cnt  = lat - 1;
            pend_addr = mem_addr;
         end
      end
   end

   task automatic pulse_start(input logic [25:0] b, input logic [25:0] l);
      @(negedge clk);
      base_addr = b;
      length    = l;
      start     = 1'b1;
      @(negedge clk);
      start     = 1'b0;
   endtask

   task automatic do_stop();
      @(negedge clk);
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
   endtask

   task automatic wait_idle(input int maxc, input string tag);
      int n = 0;
      while (busy === 1'b1 && n < maxc) begin
         @(negedge clk);
         n++;
      end
      check(tag, 32'(busy), 0);
   endtask

   // One playback: word k must be fetched from base+k and played as 0xA000+base+k, one per TD cycles.
   task automatic run_play(input string tag, input logic [25:0] b, input int len,
                           input int l, input int pct, input bit poke);
      int n;
      logic [25:0] ea;
      logic [15:0] ed;
      lat       = l;
      ready_pct = pct;
      acc_q.delete();
      obs_q.delete();
      tcyc_q.delete();
      pulse_start(b, 26'(len));
      if (poke) begin
         repeat (5) @(negedge clk);
         check({tag, "_busy"}, 32'(busy), 1);
         base_addr = 26'h7777;
         length    = 26'd9;
         start     = 1'b1;
         @(negedge clk);
         start     = 1'b0;
      end
`ifdef SAMPLE_FETCH_LOOP_EN
      n = 0;
      while (obs_q.size() < len && n < (len + 4) * TD) begin
         @(negedge clk);
         n++;
      end
      do_stop();
`endif
      wait_idle((len + 4) * TD + 200, {tag, "_idle"});
      check({tag, "_underrun"}, 32'(underrun), 0);
`ifdef SAMPLE_FETCH_LOOP_EN
      check({tag, "_acc_cnt"}, 32'(acc_q.size() >= len), 1);
`else
      check({tag, "_acc_cnt"}, 32'(acc_q.size()), 32'(len));
`endif
      check({tag, "_obs_cnt"}, 32'(obs_q.size() >= len), 1);
      for (int i = 0; i < len; i++) begin
         ea = b + 26'(i);
         ed = 16'hA000 + b[15:0] + 16'(i);
         if (i < acc_q.size()) check({tag, "_addr"}, 32'(acc_q[i]), 32'(ea));
         if (i < obs_q.size()) check({tag, "_sample"}, 32'(obs_q[i]), 32'(ed));
      end
      for (int i = 0; i + 1 < len && i + 1 < tcyc_q.size(); i++)
         check({tag, "_period"}, tcyc_q[i+1] - tcyc_q[i], TD);
   endtask

   initial begin
      int n;
      rst       = 1'b0;
      start     = 1'b0;
      stop      = 1'b0;
      base_addr = '0;
      length    = '0;

      // reset state
      repeat (3) @(negedge clk);
      check("rst_mem_req", 32'(mem_req), 0);
      check("rst_mem_addr", 32'(mem_addr), 0);
      check("rst_sample", 32'(sample), 0);
      check("rst_tick", 32'(sample_tick), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_underrun", 32'(underrun), 0);
      rst = 1'b1;
      repeat (2) @(negedge clk);

      // zero-length start is refused
      saw_req  = 0;
      saw_busy = 0;
      pulse_start(26'h50, 26'd0);
      repeat (30) @(negedge clk);
      check("len0_busy", 32'(saw_busy), 0);
      check("len0_req", 32'(saw_req), 0);

      // start and stop together: stop wins
      base_addr = 26'h60;
      length    = 26'd5;
      start     = 1'b1;
      stop      = 1'b1;
      @(negedge clk);
      start     = 1'b0;
      stop      = 1'b0;
      repeat (10) @(negedge clk);
      check("startstop_busy", 32'(saw_busy), 0);

      // starvation: RAM refuses for 3 tick periods
      ready_low = 1;
      lat       = 2;
      ready_pct = 100;
      acc_q.delete();
      obs_q.delete();
      pulse_start(26'h200, 26'd4);
      repeat (3 * TD) @(negedge clk);
      check("ur_set", 32'(underrun), 1);
      check("ur_sample_hold", 32'(sample), 0);
      check("ur_ticks", 32'(obs_q.size() >= 2), 1);
      check("ur_no_accept", 32'(acc_q.size()), 0);
      ready_low = 0;
      n = 0;
      while (sample !== 16'hA203 && n < 10 * TD) begin
         @(negedge clk);
         n++;
      end
      check("ur_data_resumed", 32'(sample), 32'h0000A203);
      check("ur_sticky", 32'(underrun), 1);
      for (int i = 0; i < 4 && i < acc_q.size(); i++)
         check("ur_addr", 32'(acc_q[i]), 32'h200 + 32'(i));
`ifdef SAMPLE_FETCH_LOOP_EN
      do_stop();
`endif
      wait_idle(10 * TD, "ur_idle");
      check("ur_sticky_idle", 32'(underrun), 1);

      // directed playback with a stray start mid-stream
      run_play("seq", 26'h100, 3, 2, 100, 1);

      // random playbacks with random latency and RAM stalls
      for (int k = 0; k < 4; k++)
         run_play("rnd", 26'($urandom), int'($urandom_range(6, 1)),
                  int'($urandom_range(3, 1)), 70, 0);

`ifdef SAMPLE_FETCH_LOOP_EN
      // endless loop over a two-word buffer
      lat       = 2;
      ready_pct = 100;
      acc_q.delete();
      obs_q.delete();
      pulse_start(26'h10, 26'd2);
      saw_idle = 0;
      n = 0;
      while ((acc_q.size() < 8 || obs_q.size() < 4) && n < 20 * TD) begin
         @(negedge clk);
         n++;
      end
      check("loop_acc_cnt", 32'(acc_q.size() >= 8), 1);
      for (int i = 0; i < 8 && i < acc_q.size(); i++)
         check("loop_addr", 32'(acc_q[i]), 32'h10 + 32'(i % 2));
      for (int i = 0; i < 4 && i < obs_q.size(); i++)
         check("loop_sample", 32'(obs_q[i]), 32'hA010 + 32'(i % 2));
      check("loop_busy", 32'(saw_idle), 0);
      do_stop();
      wait_idle(20, "loop_idle");
`endif

      // stop while a read is outstanding, with words already buffered
      lat       = 3;
      ready_pct = 100;
      acc_q.delete();
      obs_q.delete();
      pulse_start(26'h300, 26'd5);
      n = 0;
      while (acc_q.size() < 3 && n < 100) begin
         @(posedge clk);
         n++;
      end
      check("abort_acc", 32'(acc_q.size()), 3);
      @(negedge clk);
      stop = 1'b1;
      @(negedge clk);
      stop    = 1'b0;
      saw_req = 0;
      check("abort_sample", 32'(sample), 0);
      check("abort_busy", 32'(busy), 1);
      wait_idle(20, "abort_idle");
      repeat (5) @(negedge clk);
      check("abort_no_req", 32'(saw_req), 0);
      check("abort_sample_idle", 32'(sample), 0);
      run_play("post_abort", 26'h400, 2, 2, 100, 0);

      // asynchronous reset while waiting for read data
      lat = 4;
      acc_q.delete();
      pulse_start(26'h500, 26'd4);
      n = 0;
      while (acc_q.size() < 2 && n < 100) begin
         @(posedge clk);
         n++;
      end
      #3;
      rst = 1'b0;
      #1;
      check("arst_mem_req", 32'(mem_req), 0);
      check("arst_mem_addr", 32'(mem_addr), 0);
      check("arst_sample", 32'(sample), 0);
      check("arst_tick", 32'(sample_tick), 0);
      check("arst_busy", 32'(busy), 0);
      check("arst_underrun", 32'(underrun), 0);
      @(negedge clk);
      rst      = 1'b1;
      saw_req  = 0;
      saw_busy = 0;
      repeat (12) @(negedge clk);
      check("arst_late_busy", 32'(saw_busy), 0);
      check("arst_late_req", 32'(saw_req), 0);
      check("arst_late_sample", 32'(sample), 0);
      run_play("post_rst", 26'h600, 1, 2, 100, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/sample_fetch.md
SAMPLE_FETCH -- requirements
Module: sample_fetch

Interface
REQ-001 SHALL have parameter TICK_DIV, default 2083, clk cycles per output sample (48 kHz at 100 MHz).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, prefetch entries (power of two, >=2).
REQ-003 SHALL have ports: clk  in  1  system clock, rising edge; rst  in  1  asynchronous, active-low reset.
REQ-004 SHALL have ports: start  in  1  one-cycle request to begin playback; stop  in  1  one-cycle abort.
REQ-005 SHALL have ports: base_addr  in  26  first word address; length  in  26  word count.
REQ-006 SHALL have ports: mem_req  out  1  read request to RAM controller; mem_addr  out  26  word address; mem_ready  in  1  controller accepts request.
REQ-007 SHALL have ports: mem_valid  in  1  read data valid; mem_data  in  16  read word.
REQ-008 SHALL have ports: sample  out  16  current audio sample; sample_tick  out  1  new-sample strobe; busy  out  1  playback active; underrun  out  1  sticky starvation flag.

Function
REQ-009 SHALL implement FSM IDLE, FETCH, WAIT, DRAIN, ABORT.
REQ-010 IDLE: start latches base_addr/length, clears underrun, enters FETCH; start with length==0 SHALL stay IDLE.
REQ-011 FETCH: mem_req SHALL assert iff FIFO occupancy < FIFO_DEPTH; mem_addr = base + offset; transfer occurs on the cycle mem_req & mem_ready, then WAIT.
REQ-012 At most one read outstanding; mem_req SHALL stay low in WAIT.
REQ-013 WAIT: mem_valid pushes mem_data into FIFO, offset increments, returns to FETCH, or to DRAIN if offset reaches length.
REQ-014 mem_valid outside WAIT/ABORT SHALL be ignored.
REQ-015 Tick counter SHALL count 0..TICK_DIV-1 continuously while busy; sample_tick SHALL pulse exactly one cycle per wrap.
REQ-016 On tick with FIFO non-empty: sample loads FIFO head in the same cycle sample_tick is high (registered, one entry popped).
REQ-017 On tick with FIFO empty while busy: sample holds, underrun sets and stays set until next accepted start.
REQ-018 Simultaneous FIFO push and pop SHALL leave occupancy unchanged and lose no data.
REQ-019 DRAIN: no requests; when FIFO empty at a tick, go IDLE, busy low next cycle.
REQ-020 stop in FETCH/DRAIN: FIFO flushed, IDLE; stop in WAIT: ABORT, discard the pending mem_valid, then IDLE; sample SHALL become 0.
REQ-021 start while busy SHALL be ignored; start and stop in same cycle: stop wins.
REQ-022 busy SHALL be high in all states except IDLE.

Reset
REQ-023 rst low SHALL force IDLE, mem_req=0, mem_addr=0, sample=0, sample_tick=0, busy=0, underrun=0, FIFO empty, tick counter=0, independent of clk.
REQ-024 Reset mid-read SHALL drop the outstanding transfer; first state after release is IDLE.

Configuration
REQ-025 Macro SAMPLE_FETCH_LOOP_EN defined: on offset reaching length, offset SHALL wrap to 0 and FETCH continues (endless loop, no DRAIN).
REQ-026 Macro undefined: one-shot playback via DRAIN per REQ-013/REQ-019.

Structure
REQ-027 Shared package synth_pkg SHALL hold ADDR_W=26, SAMPLE_W=16, default TICK_DIV, and the FSM state encoding.
REQ-028 FIFO SHALL be a sub-module sample_fifo (sync, push/pop/count/empty/full).

Verification
REQ-029 Reset: rst low mid-WAIT -> all outputs 0, IDLE; mem_valid after release ignored.
REQ-030 base=0x100, length=3, mem model with 2-cycle latency returning 0xA000+addr -> ticks output 0xA100,0xA101,0xA102, then busy low; underrun=0.
REQ-031 length=0 start -> busy never asserts, mem_req never asserts.
REQ-032 mem_ready held low 3*TICK_DIV cycles -> underrun=1, sample holds 0; stays 1 after data resumes.
REQ-033 SAMPLE_FETCH_LOOP_EN, base=0x10, length=2 -> mem_addr sequence 0x10,0x11,0x10,0x11...; busy stays high.
REQ-034 stop asserted in WAIT -> late mem_valid discarded, sample=0, IDLE, FIFO empty.
